// File: rtl/median_filter_3x3_pipe.sv
// 3x3 median/max/min/centre filter fed one pixel column per cycle.
// Input register, window stage, partial-sort stage and select stage all advance together.
module median_filter_3x3_pipe #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  frame_start,
  input  logic [DATA_WIDTH-1:0] col_top,
  input  logic [DATA_WIDTH-1:0] col_mid,
  input  logic [DATA_WIDTH-1:0] col_bot,
  input  logic [1:0]            mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_pixel
);

  typedef logic [DATA_WIDTH-1:0] pix_t;

  function automatic pix_t max2(input pix_t a, input pix_t b);
    return (a >= b) ? a : b;
  endfunction

  function automatic pix_t min2(input pix_t a, input pix_t b);
    return (a <= b) ? a : b;
  endfunction

  function automatic pix_t max3(input pix_t a, input pix_t b, input pix_t c);
    return max2(max2(a, b), c);
  endfunction

  function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
    return min2(min2(a, b), c);
  endfunction

  // Always returns one of its operands, so no new pixel value is ever invented.
  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // input register: sorted column plus its sideband
  logic       a_acc, a_fs;
  pix_t       a_h, a_m, a_l, a_raw;
  logic [1:0] a_mode;

  // window (index 0 = newest column) and S1 slot
  pix_t       w_h [3];
  pix_t       w_m [3];
  pix_t       w_l [3];
  pix_t       raw_newest;
  logic [1:0] fill, fill_nxt;
  logic       b_vld;
  logic [1:0] b_mode;
  pix_t       b_centre;

  // S2 partial results
  pix_t       c_maxl, c_medm, c_minh, c_wmax, c_wmin, c_centre;
  logic [1:0] c_mode;
  logic       c_vld;

  pix_t       s3_pixel;

  always_comb begin
    fill_nxt = fill;
    if (a_fs)
      fill_nxt = 2'd1;
    else if (fill != 2'd3)
      fill_nxt = fill + 2'd1;
  end

  always_comb begin
    s3_pixel = c_centre;
    case (c_mode)
      2'd0:    s3_pixel = med3(c_maxl, c_medm, c_minh);
      2'd1:    s3_pixel = c_wmax;
      2'd2:    s3_pixel = c_wmin;
      default: s3_pixel = c_centre;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_acc      <= 1'b0;
      a_fs       <= 1'b0;
      a_h        <= '0;
      a_m        <= '0;
      a_l        <= '0;
      a_raw      <= '0;
      a_mode     <= '0;
      for (int i = 0; i < 3; i++) begin
        w_h[i] <= '0;
        w_m[i] <= '0;
        w_l[i] <= '0;
      end
      raw_newest <= '0;
      fill       <= '0;
      b_vld      <= 1'b0;
      b_mode     <= '0;
      b_centre   <= '0;
      c_maxl     <= '0;
      c_medm     <= '0;
      c_minh     <= '0;
      c_wmax     <= '0;
      c_wmin     <= '0;
      c_centre   <= '0;
      c_mode     <= '0;
      c_vld      <= 1'b0;
      out_valid  <= 1'b0;
      out_pixel  <= '0;
    end else if (adv) begin
      a_acc  <= in_valid;
      a_fs   <= in_valid && frame_start;
      a_h    <= max3(col_top, col_mid, col_bot);
      a_m    <= med3(col_top, col_mid, col_bot);
      a_l    <= min3(col_top, col_mid, col_bot);
      a_raw  <= col_mid;
      a_mode <= mode;

      // the window only moves for an accepted column; bubbles just carry an invalid tag
      b_vld  <= a_acc && (fill_nxt == 2'd3);
      b_mode <= a_mode;
      if (a_acc) begin
        w_h[0]     <= a_h;
        w_m[0]     <= a_m;
        w_l[0]     <= a_l;
        for (int i = 1; i < 3; i++) begin
          w_h[i] <= w_h[i-1];
          w_m[i] <= w_m[i-1];
          w_l[i] <= w_l[i-1];
        end
        raw_newest <= a_raw;
        b_centre   <= raw_newest;
        fill       <= fill_nxt;
      end

      c_maxl   <= max3(w_l[0], w_l[1], w_l[2]);
      c_medm   <= med3(w_m[0], w_m[1], w_m[2]);
      c_minh   <= min3(w_h[0], w_h[1], w_h[2]);
      c_wmax   <= max3(w_h[0], w_h[1], w_h[2]);
      c_wmin   <= min3(w_l[0], w_l[1], w_l[2]);
      c_centre <= b_centre;
      c_mode   <= b_mode;
      c_vld    <= b_vld;

      out_valid <= c_vld;
      if (c_vld)
        out_pixel <= s3_pixel;
    end
  end

endmodule

// File: tb/tb_median_filter_3x3_pipe.sv
// Self-checking bench for median_filter_3x3_pipe: directed scenarios plus random streams,
// checked against a window model that sorts the nine raw pixels.
module tb_median_filter_3x3_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         frame_start = 1'b0;
  logic [W-1:0] col_top = '0, col_mid = '0, col_bot = '0;
  logic [1:0]   mode = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_pixel;

  always #5 clk = ~clk;

  median_filter_3x3_pipe #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .frame_start(frame_start), .col_top(col_top), .col_mid(col_mid), .col_bot(col_bot),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel)
  );

  typedef struct { int t; int m; int b; } col_t;
  col_t win[$];
  int   exp_q[$];
  int   got_q[$];
  int   got_cyc[$];
  int   cyc = 0;
  int   last_acc = 0;
  int   errors = 0;
  int   checks = 0;

  // Reference: window of raw columns; result is picked from the sorted nine pixels.
  task automatic model_accept(input int t, input int m, input int b, input logic fs,
                              input logic [1:0] md);
    col_t c;
    int   v[$];
    c.t = t; c.m = m; c.b = b;
    if (fs) win.delete();
    win.push_back(c);
    if (win.size() > 3) void'(win.pop_front());
    if (win.size() == 3) begin
      foreach (win[i]) begin
        v.push_back(win[i].t); v.push_back(win[i].m); v.push_back(win[i].b);
      end
      v.sort();
      case (md)
        2'd0: exp_q.push_back(v[4]);
        2'd1: exp_q.push_back(v[8]);
        2'd2: exp_q.push_back(v[0]);
        default: exp_q.push_back(win[1].m);
      endcase
    end
  endtask

  task automatic cycle(input logic v, input logic fs, input int t, input int m, input int b,
                       input logic [1:0] md, input logic ordy, input logic r, output logic acc);
    @(negedge clk);
    rst = r; in_valid = v; frame_start = fs; mode = md; out_ready = ordy;
    col_top = t[W-1:0]; col_mid = m[W-1:0]; col_bot = b[W-1:0];
    #1;
    acc = v && in_ready && !r;
    if (!r && out_valid && ordy) begin
      got_q.push_back(int'(out_pixel));
      got_cyc.push_back(cyc);
    end
    if (r) begin
      win.delete();
      exp_q.delete();
    end else if (acc) begin
      model_accept(t, m, b, fs, md);
      last_acc = cyc + 1;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, 0, 2'd0, 1'b1, 1'b0, acc);
  endtask

  task automatic clear_logs();
    got_q.delete(); got_cyc.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    logic acc;
    cycle(1'b1, 1'b0, 7, 8, 9, 2'd0, 1'b1, 1'b1, acc);
    cycle(1'b1, 1'b0, 7, 8, 9, 2'd0, 1'b1, 1'b1, acc);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    checks++; if (out_pixel !== '0) begin errors++; $display("FAIL reset_out_pixel: got %0d expected 0", out_pixel); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    clear_logs();
  endtask

  task automatic test_basic_window();
    logic acc;
    int   acc3, acc4, g;
    clear_logs();
    cycle(1'b1, 1'b0, 10, 20, 30, 2'd0, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, 40, 50, 60, 2'd0, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, 70, 80, 90, 2'd0, 1'b1, 1'b0, acc);
    acc3 = last_acc;
    idle(6);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL basic_pulses: got %0d expected 1", got_q.size()); end
    g = (got_q.size() > 0) ? got_q[0] : -1;
    checks++; if (g != 50) begin errors++; $display("FAIL basic_median: got %0d expected 50", g); end
    g = (got_cyc.size() > 0) ? got_cyc[0] : -1;
    checks++; if (g != acc3 + 3) begin errors++; $display("FAIL basic_latency: got edge %0d expected %0d", g, acc3 + 3); end
    cycle(1'b1, 1'b0, 5, 5, 5, 2'd0, 1'b1, 1'b0, acc);
    acc4 = last_acc;
    idle(6);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL fourth_pulses: got %0d expected 2", got_q.size()); end
    g = (got_q.size() > 1) ? got_q[1] : -1;
    checks++; if (g != 50) begin errors++; $display("FAIL fourth_median: got %0d expected 50", g); end
    g = (got_cyc.size() > 1) ? got_cyc[1] : -1;
    checks++; if (g != acc4 + 3) begin errors++; $display("FAIL fourth_latency: got edge %0d expected %0d", g, acc4 + 3); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL basic_model[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_modes();
    logic acc;
    int   expv[4];
    int   g, e;
    expv = '{0, 255, 0, 255};
    for (int md = 0; md < 4; md++) begin
      clear_logs();
      cycle(1'b1, 1'b1, 0, 0, 0, md[1:0], 1'b1, 1'b0, acc);
      cycle(1'b1, 1'b0, 0, 255, 0, md[1:0], 1'b1, 1'b0, acc);
      cycle(1'b1, 1'b0, 0, 0, 0, md[1:0], 1'b1, 1'b0, acc);
      idle(5);
      g = (got_q.size() == 1) ? got_q[0] : -1;
      e = (exp_q.size() == 1) ? exp_q[0] : -2;
      checks++; if (g != expv[md]) begin errors++; $display("FAIL mode%0d_pixel: got %0d expected %0d", md, g, expv[md]); end
      checks++; if (g != e) begin errors++; $display("FAIL mode%0d_model: got %0d expected %0d", md, g, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   breaks = 0;
    clear_logs();
    for (int i = 0; i < 12; i++)
      cycle(1'b1, i == 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
            2'($urandom_range(0, 3)), 1'b1, 1'b0, acc);
    idle(6);
    checks++; if (got_q.size() != 10) begin errors++; $display("FAIL b2b_count: got %0d expected 10", got_q.size()); end
    for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] != got_cyc[i-1] + 1) breaks++;
    checks++; if (breaks != 0) begin errors++; $display("FAIL b2b_gaps: got %0d gaps expected 0", breaks); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL b2b_seq[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall();
    logic       acc, stalling;
    int         n = 0, guard = 0, stall_left = 5, held = 0;
    int         t, m, b;
    logic [1:0] md;
    clear_logs();
    t = $urandom_range(0, 255); m = $urandom_range(0, 255); b = $urandom_range(0, 255);
    md = 2'($urandom_range(0, 3));
    while (n < 12 && guard < 200) begin
      guard++;
      #1;
      stalling = (got_q.size() >= 2) && (stall_left > 0);
      if (stalling && stall_left == 5) held = int'(out_pixel);
      cycle(1'b1, n == 0, t, m, b, md, !stalling, 1'b0, acc);
      if (stalling) begin
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %0b expected 1", out_valid); end
        checks++; if (int'(out_pixel) != held) begin errors++; $display("FAIL stall_pixel: got %0d expected %0d", out_pixel, held); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %0b expected 0", in_ready); end
        stall_left--;
      end
      if (acc) begin
        n++;
        t = $urandom_range(0, 255); m = $urandom_range(0, 255); b = $urandom_range(0, 255);
        md = 2'($urandom_range(0, 3));
      end
    end
    checks++; if (guard >= 200) begin errors++; $display("FAIL stall_timeout: accepted %0d expected 12", n); end
    idle(6);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL stall_seq[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_frame_start();
    logic acc;
    clear_logs();
    for (int i = 0; i < 8; i++)
      cycle(1'b1, (i == 0) || (i == 5), $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), 2'd0, 1'b1, 1'b0, acc);
    idle(6);
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL fs_count: got %0d expected 4", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL fs_seq[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_inflight();
    logic acc;
    int   g, e;
    clear_logs();
    for (int i = 0; i < 4; i++)
      cycle(1'b1, i == 0, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
            2'd0, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, 200, 201, 202, 2'd0, 1'b1, 1'b1, acc);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flight_valid: got %0b expected 0", out_valid); end
    checks++; if (out_pixel !== '0) begin errors++; $display("FAIL rst_flight_pixel: got %0d expected 0", out_pixel); end
    idle(6);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rst_stale: got %0d results expected 0", got_q.size()); end
    cycle(1'b1, 1'b0, 1, 2, 3, 2'd0, 1'b1, 1'b0, acc);
    cycle(1'b1, 1'b0, 9, 8, 7, 2'd0, 1'b1, 1'b0, acc);
    idle(6);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rst_first_two: got %0d results expected 0", got_q.size()); end
    cycle(1'b1, 1'b0, 4, 6, 5, 2'd0, 1'b1, 1'b0, acc);
    idle(6);
    g = (got_q.size() == 1) ? got_q[0] : -1;
    e = (exp_q.size() == 1) ? exp_q[0] : -2;
    checks++; if (g != 5) begin errors++; $display("FAIL rst_third: got %0d expected 5", g); end
    checks++; if (g != e) begin errors++; $display("FAIL rst_third_model: got %0d expected %0d", g, e); end
  endtask

  task automatic test_random();
    logic       acc, v, fs, ordy;
    int         t, m, b;
    logic [1:0] md;
    clear_logs();
    for (int i = 0; i < 300; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      fs   = ($urandom_range(0, 19) == 0);
      ordy = ($urandom_range(0, 9) < 7);
      t = $urandom_range(0, 255); m = $urandom_range(0, 255); b = $urandom_range(0, 255);
      md = 2'($urandom_range(0, 3));
      cycle(v, fs, t, m, b, md, ordy, 1'b0, acc);
    end
    idle(8);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++; if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL rand_seq[%0d]: got %0d expected %0d", i, got_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_modes();
    test_back_to_back();
    test_stall();
    test_frame_start();
    test_reset_inflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/median_filter_3x3_pipe.md
MEDIAN_FILTER_3X3_PIPE -- requirements
Module: median_filter_3x3_pipe

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, setting the pixel width in bits (legal range 1..16).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: an input column is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a column this cycle.
REQ-006 The block SHALL have port frame_start, input, 1 bit: qualified by in_valid; the column is the first of a new window.
REQ-007 The block SHALL have ports col_top, col_mid and col_bot, input, DATA_WIDTH bits each: one pixel column (rows 0, 1 and 2).
REQ-008 The block SHALL have port mode, input, 2 bits: 0 median, 1 max, 2 min, 3 centre pass-through; it is sampled with the column.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_pixel holds a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream stage accepts out_pixel.
REQ-011 The block SHALL have port out_pixel, output, DATA_WIDTH bits: the filtered pixel.

Function
REQ-012 Advance SHALL be defined as adv = !out_valid || out_ready, and in_ready SHALL equal adv; all pipeline registers SHALL update only when adv is 1.
REQ-013 A column SHALL be accepted when in_valid and in_ready are both 1; no other event SHALL alter the window.
REQ-014 Stage S1, on acceptance:
- sort the column into H >= M >= L;
- shift the sorted triple into a 3-column window (oldest column discarded);
- keep the raw col_mid of the middle window column as the centre pixel;
- register mode alongside the column.
REQ-015 A window fill counter (0..3) SHALL increment on each accepted column and saturate at 3; frame_start SHALL force it to 1, with that column as the sole valid column.
REQ-016 A column SHALL produce a result only if the fill counter is 3 after its acceptance; otherwise it SHALL carry an invalid tag through the pipeline.
REQ-017 Stage S2 SHALL register the following:
- maxL = max of the three L values;
- medM = median of the three M values;
- minH = min of the three H values;
- winMax = max of the three H values;
- winMin = min of the three L values;
- the centre pixel, the mode and the valid tag.
REQ-018 Stage S3 SHALL compute median(maxL, medM, minH), which is the exact median of the 9 pixels.
REQ-019 Stage S3 SHALL select by mode (median, winMax, winMin or centre) into out_pixel, and set out_valid from the valid tag.
REQ-020 Latency SHALL be 3 advancing cycles: a column accepted at edge T SHALL yield out_valid=1 after edge T+3 when out_ready is held 1.
REQ-021 Throughput SHALL be one result per cycle once the window is full and out_ready is 1.
REQ-022 While out_valid=1 and out_ready=0, out_pixel and out_valid SHALL hold, in_ready SHALL be 0, and no in-flight data SHALL be lost or duplicated.
REQ-023 Comparisons SHALL be unsigned at full DATA_WIDTH; equal values SHALL give a deterministic result, and no value SHALL be created that is not an input pixel.
REQ-024 A mode change SHALL affect only columns accepted at or after the change; in-flight results SHALL keep the mode they were sampled with.
REQ-025 An invalid-tagged slot reaching S3 SHALL leave out_valid=0; out_pixel is then don't-care, but it SHALL hold its previous value.

Reset
REQ-026 When rst=1 at a clock edge, the following SHALL be 0 after that edge: out_valid, out_pixel, the fill counter, all window and pipeline registers, and all valid tags.
REQ-027 Reset SHALL take priority over acceptance and advance; columns in flight at reset SHALL be discarded.
REQ-028 After reset, the first two accepted columns SHALL produce no output.

Verification
REQ-029 The bench SHALL cover: mode 0, columns (10,20,30), (40,50,60), (70,80,90), out_ready=1 -> exactly one out_valid pulse, 3 cycles after the third column, with out_pixel=50.
REQ-030 The bench SHALL cover: a fourth column (5,5,5) following REQ-029 -> the next result has out_pixel=50, from the window {40..90,5,5,5}.
REQ-031 The bench SHALL cover: columns (0,0,0), (0,255,0), (0,0,0) repeated in modes 0, 1, 2 and 3 -> out_pixel = 0, 255, 0 and 255 respectively.
REQ-032 The bench SHALL cover: out_ready=0 for 5 cycles while out_valid=1 -> out_pixel is stable, in_ready=0, and the result sequence after release matches the no-stall reference.
REQ-033 The bench SHALL cover: frame_start asserted on a column mid-stream -> that column and the next accepted column produce no output, and the third produces the median of the new window only.
REQ-034 The bench SHALL cover: rst pulsed with 2 results in flight -> out_valid=0 after the edge, no stale result appears, and REQ-028 holds.
